alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: runs a 4-bit ALU slice nibble by nibble over a 4*NIB-bit word.
// Optional feature: define ALU_SEQ_ABORT_EN to add the abort_i input.
module alu_seq #(
    parameter int NIB = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [3:0]        sel_i,
    input  logic [4*NIB-1:0]  op_a_i,
    input  logic [4*NIB-1:0]  op_b_i,
    input  logic              carry_n_i,
`ifdef ALU_SEQ_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [4*NIB-1:0]  result_o,
    output logic              carry_n_o,
    output logic              eq_o,
    output logic              alu_mode_o,
    output logic [3:0]        alu_sel_o,
    output logic [3:0]        alu_a_o,
    output logic [3:0]        alu_b_o,
    output logic              alu_carry_o,
    input  logic [3:0]        alu_f_i,
    input  logic              alu_carry_i,
    input  logic              alu_cmp_i
);

    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [KW-1:0]   k_q;
    logic            mode_q;
    logic [3:0]      sel_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic            acc_eq_q;
    logic [W-1:0]    work_q;
    logic [W-1:0]    work_d;
    logic [W-1:0]    result_q;
    logic            cout_q;
    logic            eq_q;
    logic            run_go;
    logic            last;
    logic [KW+1:0]   idx;

    assign idx  = {k_q, 2'b00};
    assign last = (k_q == KW'(NIB - 1));

    // State register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, slice drive and working-word merge.
    always_comb begin
        state_d     = state_q;
        run_go      = 1'b0;
        work_d      = work_q;
        alu_mode_o  = 1'b0;
        alu_sel_o   = 4'h0;
        alu_a_o     = 4'h0;
        alu_b_o     = 4'h0;
        alu_carry_o = 1'b1;
        work_d[idx +: 4] = alu_f_i;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                alu_mode_o  = mode_q;
                alu_sel_o   = sel_q;
                alu_a_o     = a_q[idx +: 4];
                alu_b_o     = b_q[idx +: 4];
                alu_carry_o = carry_q;
`ifdef ALU_SEQ_ABORT_EN
                if (abort_i) begin
                    state_d = IDLE;
                end else
`endif
                begin
                    run_go = 1'b1;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch, nibble walk and result capture on the last nibble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q      <= '0;
            mode_q   <= 1'b0;
            sel_q    <= 4'h0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b1;
            acc_eq_q <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b1;
            eq_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && start_i) begin
                k_q      <= '0;
                mode_q   <= mode_i;
                sel_q    <= sel_i;
                a_q      <= op_a_i;
                b_q      <= op_b_i;
                carry_q  <= carry_n_i;
                acc_eq_q <= 1'b1;
            end
            if (run_go) begin
                work_q   <= work_d;
                acc_eq_q <= acc_eq_q & alu_cmp_i;
                carry_q  <= alu_carry_i;
                k_q      <= k_q + KW'(1);
                if (last) begin
                    result_q <= work_d;
                    cout_q   <= alu_carry_i;
                    eq_q     <= acc_eq_q & alu_cmp_i;
                end
            end
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign result_o  = result_q;
    assign carry_n_o = cout_q;
    assign eq_o      = eq_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with a 4-bit ALU slice model.
// Define ALU_SEQ_ABORT_EN to also exercise abort_i.
module tb_alu_seq;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          mode_i;
    logic [3:0]    sel_i;
    logic [W-1:0]  op_a_i;
    logic [W-1:0]  op_b_i;
    logic          carry_n_i;
`ifdef ALU_SEQ_ABORT_EN
    logic          abort_i;
`endif
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;
    logic          carry_n_o;
    logic          eq_o;
    logic          alu_mode_o;
    logic [3:0]    alu_sel_o;
    logic [3:0]    alu_a_o;
    logic [3:0]    alu_b_o;
    logic          alu_carry_o;
    logic [3:0]    alu_f_i;
    logic          alu_carry_i;
    logic          alu_cmp_i;

    alu_seq #(.NIB(NIB)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .carry_n_i   (carry_n_i),
`ifdef ALU_SEQ_ABORT_EN
        .abort_i     (abort_i),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .carry_n_o   (carry_n_o),
        .eq_o        (eq_o),
        .alu_mode_o  (alu_mode_o),
        .alu_sel_o   (alu_sel_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_carry_o (alu_carry_o),
        .alu_f_i     (alu_f_i),
        .alu_carry_i (alu_carry_i),
        .alu_cmp_i   (alu_cmp_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // 74181-style function on a w-bit word (active-high data, active-low
    // carries). Arithmetic: F = X + Y + cin; logic: F = ~(X ^ Y).
    // Returns {carry_n_out, all_ones, F}.
    function automatic logic [17:0] alu_ref(
        input logic        m,
        input logic [3:0]  s,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        cn,
        input int          w
    );
        logic [16:0] mask;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] f;
        logic [16:0] sum;
        mask = (17'd1 << w) - 17'd1;
        x = (a | (s[0] ? b : 16'h0) | (s[1] ? ~b : 16'h0)) & mask[15:0];
        y = a & ((s[3] ? b : 16'h0) | (s[2] ? ~b : 16'h0)) & mask[15:0];
        sum = {1'b0, x} + {1'b0, y} + {16'h0, ~cn};
        f = m ? (~(x ^ y) & mask[15:0]) : (sum[15:0] & mask[15:0]);
        return {~sum[w], (f == mask[15:0]), f};
    endfunction

    function automatic logic [5:0] slice(
        input logic       m,
        input logic [3:0] s,
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cn
    );
        logic [17:0] r;
        r = alu_ref(m, s, {12'h0, a}, {12'h0, b}, cn, 4);
        return {r[17], r[16], r[3:0]};
    endfunction

    // The attached slice is pure combinational logic.
    logic [5:0] sl;
    always_comb sl = slice(alu_mode_o, alu_sel_o, alu_a_o, alu_b_o, alu_carry_o);
    assign alu_f_i     = sl[3:0];
    assign alu_cmp_i   = sl[4];
    assign alu_carry_i = sl[5];

    typedef struct {
        logic [W-1:0] res;
        logic         cn;
        logic         eq;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input string nm, input logic [W-1:0] res,
                        input logic cn, input logic eq, input int dc);
        exp_t e;
        e.res  = res;
        e.cn   = cn;
        e.eq   = eq;
        e.cyc  = dc;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: every done_o cycle is matched against the oldest expectation.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (done_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, 32'(result_o), 32'(e.res));
                chk({e.name, "_carry_n"}, 32'(carry_n_o), 32'(e.cn));
                chk({e.name, "_eq"}, 32'(eq_o), 32'(e.eq));
                chk({e.name, "_latency"}, cyc, e.cyc);
                chk({e.name, "_busy"}, 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_o !== 1'b0 && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout cycle=%0d", cyc);
        end
    endtask

    // Issue one start pulse; dc is the cycle in which done_o must be seen.
    task automatic go(input logic m, input logic [3:0] s,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cn, output int dc);
        wait_idle();
        mode_i    = m;
        sel_i     = s;
        op_a_i    = a;
        op_b_i    = b;
        carry_n_i = cn;
        start_i   = 1'b1;
        dc        = cyc + 1 + NIB;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    task automatic run_ref(input string nm, input logic m,
                           input logic [3:0] s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cn);
        int dc;
        logic [17:0] r;
        r = alu_ref(m, s, a, b, cn, W);
        go(m, s, a, b, cn, dc);
        push(nm, r[15:0], r[17], r[16], dc);
    endtask

    initial begin : stim
        int dc;
        int c;
        logic [17:0] r;
        rst_i     = 1'b1;
        start_i   = 1'b0;
        mode_i    = 1'b0;
        sel_i     = 4'h0;
        op_a_i    = '0;
        op_b_i    = '0;
        carry_n_i = 1'b1;
`ifdef ALU_SEQ_ABORT_EN
        abort_i   = 1'b0;
`endif
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_eq", 32'(eq_o), 32'd0);
        chk("rst_carry_n", 32'(carry_n_o), 32'd1);
        chk("rst_alu_carry", 32'(alu_carry_o), 32'd1);
        chk("rst_alu_drv", {alu_mode_o, alu_sel_o, alu_a_o, alu_b_o}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        go(1'b0, 4'b1001, 16'h1234, 16'h0FFF, 1'b1, dc);
        push("add", 16'h2233, 1'b1, 1'b0, dc);
        go(1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b1, dc);
        push("ovf", 16'h0000, 1'b0, 1'b0, dc);
        go(1'b0, 4'b0110, 16'h5A5A, 16'h5A5A, 1'b1, dc);
        push("cmp_eq", 16'hFFFF, 1'b1, 1'b1, dc);
        go(1'b0, 4'b0110, 16'h5A5A, 16'h5A5B, 1'b1, dc);
        push("cmp_ne", 16'hFFFE, 1'b1, 1'b0, dc);

        // Logic mode with a stray start pulse while running.
        r = alu_ref(1'b1, 4'b0110, 16'hF0F0, 16'h0FF0, 1'b1, W);
        go(1'b1, 4'b0110, 16'hF0F0, 16'h0FF0, 1'b1, dc);
        push("logic", 16'hFF00, r[17], 1'b0, dc);
        @(negedge clk_i);
        chk("busy_run", 32'(busy_o), 32'd1);
        mode_i  = 1'b0;
        sel_i   = 4'b1001;
        op_a_i  = 16'h1111;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;

        // Start held through DONE: taken again at the first IDLE edge.
        wait_idle();
        r = alu_ref(1'b0, 4'b1001, 16'h0F0F, 16'h0202, 1'b0, W);
        mode_i    = 1'b0;
        sel_i     = 4'b1001;
        op_a_i    = 16'h0F0F;
        op_b_i    = 16'h0202;
        carry_n_i = 1'b0;
        start_i   = 1'b1;
        c = cyc;
        push("hold1", r[15:0], r[17], r[16], c + 1 + NIB);
        push("hold2", r[15:0], r[17], r[16], c + 3 + 2 * NIB);
        repeat (NIB + 3) @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;

        // Reset in the second RUN cycle abandons the operation.
        go(1'b0, 4'b1001, 16'h0001, 16'h0001, 1'b1, dc);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_result", 32'(result_o), 32'd0);
        chk("mid_rst_carry_n", 32'(carry_n_o), 32'd1);
        chk("mid_rst_alu_carry", 32'(alu_carry_o), 32'd1);
        #2;
        rst_i = 1'b0;
        repeat (NIB + 3) @(negedge clk_i);
        chk("post_rst_idle", 32'(busy_o), 32'd0);

`ifdef ALU_SEQ_ABORT_EN
        go(1'b0, 4'b1001, 16'h1234, 16'h0FFF, 1'b1, dc);
        push("pre_abort", 16'h2233, 1'b1, 1'b0, dc);
        go(1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b1, dc);
        @(negedge clk_i);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_result", 32'(result_o), 32'h2233);
        chk("abort_carry_n", 32'(carry_n_o), 32'd1);
        repeat (NIB + 2) @(negedge clk_i);
`endif

        for (int i = 0; i < 40; i++) begin
            run_ref("rnd", 1'($urandom_range(0, 1)), 4'($urandom),
                    16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end

        c = 0;
        while (sb.size() != 0 && c < 100) begin
            @(negedge clk_i);
            c++;
        end
        chk("sb_empty", sb.size(), 0);
        chk("idle_alu_carry", 32'(alu_carry_o), 32'd1);
        chk("idle_alu_drv", {alu_mode_o, alu_sel_o, alu_a_o, alu_b_o}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
